// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the
// unified memory. The arbiter uses the slave view; the core/memory side
// (or a testbench standing in for them) uses the master view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;

    // Data-access port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    // Memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_rdata,
        output if_ready, if_rdata, if_rvalid,
        output d_ready, d_rdata, d_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_rdata,
        input  if_ready, if_rdata, if_rvalid,
        input  d_ready, d_rdata, d_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, synchronous-read memory between the
// instruction-fetch and data-access ports. One transaction in flight; the
// data port has fixed priority, but after STARVE_MAX consecutive data
// grants with a fetch pending the fetch port is forced through.
// Optional: define ARB_PERF_CNT_EN to add grant/conflict counters.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    unified_mem_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]            perf_if_grants,
    output logic [31:0]            perf_d_grants,
    output logic [31:0]            perf_conflicts
`endif
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MEM_LAT + 1);
    localparam int SW     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              d_we_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_rvalid_q, d_rvalid_q;

    logic last_cycle;
    logic eligible;
    logic if_pri;
    logic both_req;
    logic if_ready;
    logic d_ready;
    logic if_grant;
    logic d_grant;

    // Arbitration: a grant may happen in IDLE or in the final latency cycle;
    // readies are forced low while reset is asserted.
    always_comb begin
        last_cycle = (state_q != IDLE) && (cnt_q == CNT_W'(MEM_LAT));
        eligible   = reset && ((state_q == IDLE) || last_cycle);
        if_pri     = (starve_q == SW'(STARVE_MAX));
        both_req   = bus.if_req && bus.d_req;
        if_ready   = eligible && !(both_req && !if_pri);
        d_ready    = eligible && !(both_req && if_pri);
        if_grant   = bus.if_req && if_ready;
        d_grant    = bus.d_req && d_ready;
    end

    // FSM next state and latency counter (counter runs 1..MEM_LAT while busy).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (d_grant) begin
                    state_d = BUSY_D;
                    cnt_d   = CNT_W'(1);
                end else if (if_grant) begin
                    state_d = BUSY_IF;
                    cnt_d   = CNT_W'(1);
                end
            end
            BUSY_IF, BUSY_D: begin
                if (d_grant) begin
                    state_d = BUSY_D;
                    cnt_d   = CNT_W'(1);
                end else if (if_grant) begin
                    state_d = BUSY_IF;
                    cnt_d   = CNT_W'(1);
                end else if (last_cycle) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Starvation counter: counts data grants that bypass a pending fetch.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || if_grant) begin
            starve_d = '0;
        end else if (d_grant && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Memory request is driven straight from the winning port in the grant cycle.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (d_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_wstrb = bus.d_wstrb;
        end else if (if_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.if_addr;
        end
    end

    // State, latency and starvation registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            d_we_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            if (d_grant) begin
                d_we_q <= bus.d_we;
            end
        end
    end

    // Completion: capture memory data in the last latency cycle, pulse rvalid next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= last_cycle && (state_q == BUSY_IF);
            d_rvalid_q  <= last_cycle && (state_q == BUSY_D);
            if (last_cycle && (state_q == BUSY_IF)) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (last_cycle && (state_q == BUSY_D) && !d_we_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_ready  = if_ready;
    assign bus.d_ready   = d_ready;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_d_q, perf_conf_q;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_q   <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else begin
            if (if_grant) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (d_grant) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
            if (both_req && (state_q == IDLE)) begin
                perf_conf_q <= perf_conf_q + 32'd1;
            end
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_conf_q;
`endif

endmodule
